// File: rtl/bank_read_router_k2.sv
// bank_read_router_k2: grants one slot per bank, issues SRAM reads, routes returned words back to their slots.
`timescale 1ns/1ps
module bank_read_router_k2 #(
  parameter int BANK_NUM = 16,
  parameter int BANK_W = 5,
  parameter int MA_W = 4,
  parameter int DATA_W = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_en,
  input  logic                       req_done,
  input  logic [2:0]                 req_l,
  input  logic [BANK_NUM*BANK_W-1:0] req_bn,
  input  logic [BANK_NUM*MA_W-1:0]   req_ma,
  output logic [BANK_NUM-1:0]        bank_rd_en,
  output logic [BANK_NUM*MA_W-1:0]   bank_addr,
  input  logic [BANK_NUM*DATA_W-1:0] bank_rdata,
  output logic [BANK_NUM-1:0]        slot_valid,
  output logic [BANK_NUM*DATA_W-1:0] slot_rdata,
  output logic [2:0]                 l_out,
  output logic                       done_out,
  output logic                       conflict_err,
  output logic                       overrun_err,
  output logic [15:0]                grp_cnt
);
  localparam int SW = $clog2(BANK_NUM);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [1:0] drain_cnt;
  logic acc, conflict, d1, d2;
  logic [2:0] l1, l2;
  logic [BANK_NUM-1:0] live, own_v_n, own_v2, vld_n;
  logic [BANK_NUM-1:0][SW-1:0] bn_lo, own_n, own1, own2;
  logic [BANK_NUM-1:0][MA_W-1:0] ma, addr_n;
  logic [BANK_NUM-1:0][DATA_W-1:0] dat_n;
  assign acc = req_en && state != DRAIN;
  for (genvar i = 0; i < BANK_NUM; i++) begin : g_slot
    assign live[i] = acc && req_bn[i*BANK_W +: BANK_W] < BANK_W'(BANK_NUM);
    assign bn_lo[i] = req_bn[i*BANK_W +: SW];
    assign ma[i] = req_ma[i*MA_W +: MA_W];
  end
  // ascending scan: the first live slot on a bank wins, later ones are conflicts
  always_comb begin
    own_v_n = '0;
    own_n = '0;
    addr_n = '0;
    conflict = 1'b0;
    for (int s = 0; s < BANK_NUM; s++) begin
      if (live[s] && own_v_n[bn_lo[s]]) conflict = 1'b1;
      else if (live[s]) begin
        own_v_n[bn_lo[s]] = 1'b1;
        own_n[bn_lo[s]] = SW'(s);
        addr_n[bn_lo[s]] = ma[s];
      end
    end
  end
  always_comb begin
    vld_n = '0;
    dat_n = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      if (own_v2[b]) begin
        vld_n[own2[b]] = 1'b1;
        dat_n[own2[b]] = bank_rdata[b*DATA_W +: DATA_W];
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      drain_cnt <= '0;
      grp_cnt <= '0;
      conflict_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (state == DRAIN && req_en) overrun_err <= 1'b1;
      if (acc && conflict) conflict_err <= 1'b1;
      if (acc) grp_cnt <= grp_cnt + 16'd1;
      if (state == DRAIN) begin
        drain_cnt <= drain_cnt == 2'd2 ? 2'd0 : drain_cnt + 2'd1;
        if (drain_cnt == 2'd2) begin
          state <= IDLE;
          grp_cnt <= '0;
        end
      end else if (acc) state <= req_done ? DRAIN : RUN;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_rd_en <= '0;
      bank_addr <= '0;
      own1 <= '0;
      own2 <= '0;
      own_v2 <= '0;
      l1 <= '0;
      l2 <= '0;
      d1 <= 1'b0;
      d2 <= 1'b0;
      slot_valid <= '0;
      slot_rdata <= '0;
      l_out <= '0;
      done_out <= 1'b0;
    end else begin
      bank_rd_en <= own_v_n;
      bank_addr <= addr_n;
      own1 <= own_n;
      own2 <= own1;
      own_v2 <= bank_rd_en;
      l1 <= acc ? req_l : 3'd0;
      l2 <= l1;
      d1 <= acc && req_done;
      d2 <= d1;
      slot_valid <= vld_n;
      slot_rdata <= dat_n;
      l_out <= l2;
      done_out <= d2;
    end
  end
endmodule

// File: tb/tb_bank_read_router_k2.sv
// tb_bank_read_router_k2: table-driven vectors plus hand sequences, checked through a latency-tagged scoreboard.
`timescale 1ns/1ps
module tb_bank_read_router_k2;
  localparam int N = 16, BW = 5, MW = 4, DW = 64;
  logic clk = 0, rst = 0, req_en = 0, req_done = 0;
  logic [2:0] req_l = 0;
  logic [N*BW-1:0] req_bn;
  logic [N*MW-1:0] req_ma = '0;
  logic [N-1:0] bank_rd_en, slot_valid;
  logic [N*MW-1:0] bank_addr;
  logic [N*DW-1:0] bank_rdata = '0, slot_rdata;
  logic [2:0] l_out;
  logic done_out, conflict_err, overrun_err;
  logic [15:0] grp_cnt;
  typedef struct { logic en; logic done; logic [2:0] l; logic [N*BW-1:0] bn; logic [N*MW-1:0] ma; logic [15:0] xv; } vec_t;
  typedef struct { int due; logic [15:0] en; logic [N*MW-1:0] addr; } bexp_t;
  typedef struct { int due; logic [15:0] vld; logic [N*DW-1:0] dat; logic [2:0] l; logic done; } sexp_t;
  vec_t tbl[$];
  bexp_t bq[$];
  sexp_t sq[$];
  bexp_t be;
  sexp_t se;
  int cyc = 0, n_chk = 0, n_fail = 0;
  bit mon_on = 0, m_drain = 0, m_conf = 0, m_ovr = 0;
  int m_dc = 0, m_gcnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bank_read_router_k2 dut (
    .clk(clk), .rst(rst), .req_en(req_en), .req_done(req_done), .req_l(req_l),
    .req_bn(req_bn), .req_ma(req_ma), .bank_rd_en(bank_rd_en), .bank_addr(bank_addr),
    .bank_rdata(bank_rdata), .slot_valid(slot_valid), .slot_rdata(slot_rdata),
    .l_out(l_out), .done_out(done_out), .conflict_err(conflict_err),
    .overrun_err(overrun_err), .grp_cnt(grp_cnt)
  );

  // SRAM: returns {bank, addr} one cycle after the strobe
  always @(posedge clk)
    for (int b = 0; b < N; b++)
      bank_rdata[b*DW +: DW] <= bank_rd_en[b] ? 64'(b * 256 + int'(bank_addr[b*MW +: MW])) : 64'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [N*BW-1:0] all_idle();
    logic [N*BW-1:0] v;
    for (int s = 0; s < N; s++) v[s*BW +: BW] = 5'd16;
    return v;
  endfunction

  task automatic step(input logic en, input logic done, input logic [2:0] l, input logic [N*BW-1:0] bn,
                      input logic [N*MW-1:0] ma, input logic [15:0] xv, input bit use_xv);
    logic [15:0] vld, ben;
    logic [N*DW-1:0] dat;
    logic [N*MW-1:0] baddr;
    bit acc, conf, win;
    int bs, bt;
    chk("grp_cnt", grp_cnt, 64'(m_gcnt));
    chk("conflict_err", conflict_err, m_conf);
    chk("overrun_err", overrun_err, m_ovr);
    req_en = en; req_done = done; req_l = l; req_bn = bn; req_ma = ma;
    acc = en && !m_drain && rst;
    vld = '0; ben = '0; dat = '0; baddr = '0; conf = 0;
    if (acc) begin
      for (int s = 0; s < N; s++) begin
        bs = int'(bn[s*BW +: BW]);
        if (bs < 16) begin
          win = 1;
          for (int t = 0; t < s; t++) begin
            bt = int'(bn[t*BW +: BW]);
            if (bt == bs) win = 0;
          end
          if (win) begin
            vld[s] = 1'b1;
            dat[s*DW +: DW] = 64'(bs * 256 + int'(ma[s*MW +: MW]));
            ben[bs] = 1'b1;
            baddr[bs*MW +: MW] = ma[s*MW +: MW];
          end else conf = 1;
        end
      end
      bq.push_back('{cyc + 1, ben, baddr});
      sq.push_back('{cyc + 3, use_xv ? xv : vld, dat, l, done});
    end
    if (rst) begin
      if (m_drain) begin
        if (en) m_ovr = 1;
        if (m_dc == 2) begin m_drain = 0; m_dc = 0; m_gcnt = 0; end
        else m_dc++;
      end else if (acc) begin
        m_gcnt = (m_gcnt + 1) & 16'hFFFF;
        if (done) m_drain = 1;
        if (conf) m_conf = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 3'd0, all_idle(), '0, '0, 0);
  endtask

  always @(negedge clk) if (mon_on) begin
    if (bq.size() > 0 && bq[0].due == cyc) begin
      be = bq.pop_front();
      chk("bank_rd_en", bank_rd_en, be.en);
      chk("bank_addr", bank_addr, be.addr);
    end else chk("bank_rd_en idle", bank_rd_en, 0);
    if (sq.size() > 0 && sq[0].due == cyc) begin
      se = sq.pop_front();
      chk("slot_valid", slot_valid, se.vld);
      for (int s = 0; s < N; s++) chk($sformatf("slot_rdata[%0d]", s), slot_rdata[s*DW +: DW], se.dat[s*DW +: DW]);
      chk("l_out", l_out, se.l);
      chk("done_out", done_out, se.done);
    end else begin
      chk("slot_valid idle", slot_valid, 0);
      chk("done_out idle", done_out, 0);
    end
  end

  initial begin
    logic [N*BW-1:0] bn;
    logic [N*MW-1:0] ma;
    logic [15:0] mask;
    req_bn = all_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst bank_rd_en", bank_rd_en, 0);
    chk("rst bank_addr", bank_addr, 0);
    chk("rst slot_valid", slot_valid, 0);
    chk("rst slot_rdata", 64'(|slot_rdata), 0);
    chk("rst l_out", l_out, 0);
    chk("rst done_out", done_out, 0);
    chk("rst errors", {conflict_err, overrun_err}, 0);
    chk("rst grp_cnt", grp_cnt, 0);
    rst = 1;
    mon_on = 1;
    idle(2);
    for (int s = 0; s < N; s++) begin bn[s*BW +: BW] = BW'(s); ma[s*MW +: MW] = MW'(15 - s); end
    tbl.push_back('{1, 1, 3'd1, bn, ma, 16'hFFFF});
    for (int i = 0; i < 4; i++) tbl.push_back('{0, 0, 3'd0, all_idle(), '0, 16'h0});
    for (int g = 0; g < 8; g++) begin
      mask = g % 2 == 0 ? 16'h3333 : 16'hCCCC;
      for (int s = 0; s < N; s++) begin bn[s*BW +: BW] = mask[s] ? BW'(s) : 5'd16; ma[s*MW +: MW] = MW'(s); end
      tbl.push_back('{1, g == 7, 3'(g), bn, ma, mask});
    end
    for (int i = 0; i < 4; i++) tbl.push_back('{0, 0, 3'd0, all_idle(), '0, 16'h0});
    bn = all_idle();
    ma = '0;
    bn[3*BW +: BW] = 5'd5; ma[3*MW +: MW] = 4'hA;
    bn[7*BW +: BW] = 5'd5; ma[7*MW +: MW] = 4'h6;
    bn[0 +: BW] = 5'd0; ma[0 +: MW] = 4'h3;
    tbl.push_back('{1, 1, 3'd2, bn, ma, 16'h0009});
    for (int i = 0; i < 4; i++) tbl.push_back('{0, 0, 3'd0, all_idle(), '0, 16'h0});
    for (int g = 0; g < 6; g++) begin
      for (int s = 0; s < N; s++) begin bn[s*BW +: BW] = BW'((s + g) % 16); ma[s*MW +: MW] = MW'(s); end
      tbl.push_back('{1, g == 5, 3'(g), bn, ma, 16'hFFFF});
    end
    for (int i = 0; i < 4; i++) tbl.push_back('{0, 0, 3'd0, all_idle(), '0, 16'h0});
    foreach (tbl[i]) step(tbl[i].en, tbl[i].done, tbl[i].l, tbl[i].bn, tbl[i].ma, tbl[i].xv, 1);
    // overrun: a group presented the cycle after the done group
    for (int s = 0; s < N; s++) begin bn[s*BW +: BW] = BW'(s); ma[s*MW +: MW] = MW'(s); end
    step(1, 1, 3'd3, bn, ma, '0, 0);
    step(1, 0, 3'd4, bn, ma, '0, 0);
    idle(5);
    // reset asserted mid-cycle two cycles into a 4-group burst
    step(1, 0, 3'd1, bn, ma, '0, 0);
    step(1, 0, 3'd2, bn, ma, '0, 0);
    req_en = 1; req_done = 0; req_l = 3'd3;
    #2 rst = 0;
    #1;
    chk("async bank_rd_en", bank_rd_en, 0);
    chk("async bank_addr", bank_addr, 0);
    chk("async slot_valid", slot_valid, 0);
    chk("async slot_rdata", 64'(|slot_rdata), 0);
    chk("async l_out/done", {l_out, done_out}, 0);
    chk("async errors", {conflict_err, overrun_err}, 0);
    chk("async grp_cnt", grp_cnt, 0);
    bq.delete();
    sq.delete();
    m_drain = 0; m_dc = 0; m_gcnt = 0; m_conf = 0; m_ovr = 0;
    step(1, 1, 3'd4, bn, ma, '0, 0);
    rst = 1;
    idle(6);
    chk("scoreboard drained", 64'(bq.size() + sq.size()), 0);
    mon_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bank_read_router_k2.md
# bank_read_router_k2

Memory-side endpoint for the k2 address-generation path. Accepts up to 16 bank/address request slots per cycle (BN/MA pairs for offsets add0..add7, bank index 16 = slot idle), issues one read per bank to the 16-bank coefficient SRAM, and routes returned words back to the requesting slot in lane order. Sits between the k2 address generator and the butterfly datapath, with slot-aligned valid, stage tag (l) and done signalling.

## Interface
- BANK_NUM, 16, number of SRAM banks; also the idle bank code
- BANK_W, 5, bank index width (holds 0..16)
- MA_W, 4, per-bank word address width
- DATA_W, 64, SRAM word width
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- req_en  input  1  request slots valid this cycle
- req_done  input  1  marks the last request group of the stage
- req_l  input  3  stage tag for this group
- req_bn  input  16*BANK_W  slot s bank index at [s*BANK_W +: BANK_W]; slot 2k = BN0 offset k, slot 2k+1 = BN1 offset k
- req_ma  input  16*MA_W  slot s word address, same packing
- bank_rd_en  output  16  per-bank read strobe, registered
- bank_addr  output  16*MA_W  per-bank address, registered
- bank_rdata  input  16*DATA_W  per-bank read data, valid exactly one cycle after bank_rd_en
- slot_valid  output  16  slot s data present on slot_rdata
- slot_rdata  output  16*DATA_W  routed read data, slot s at [s*DATA_W +: DATA_W]
- l_out  output  3  stage tag aligned with slot_valid
- done_out  output  1  one-cycle pulse aligned with the last group's data
- conflict_err  output  1  sticky: two live slots hit one bank in one cycle
- overrun_err  output  1  sticky: req_en high while DRAIN
- grp_cnt  output  16  accepted groups since last IDLE, wraps at 0xFFFF

## Operation
- Slot live when req_en=1, FSM in IDLE or RUN, and req_bn < 16; bn >= 16 is idle, never an error.
- Stage 1 (decode): for each bank b, grant lowest-index live slot with bn=b; register bank_rd_en[b]=1, bank_addr[b]=that slot's ma, owner slot index (4 bits) and owner-valid per bank. Losing slots are dropped (no retry), set conflict_err.
- Stage 2: owner table, l and done delayed one cycle to align with bank_rdata.
- Stage 3 (route): slot_rdata[s] = bank_rdata[b] for bank b owned by s; slot_valid[s]=1 only for granted slots; unowned slots drive data 0.
- FSM: IDLE -> RUN on accepted req_en; RUN -> DRAIN on accepted group with req_done=1 (same-cycle IDLE req_en+req_done goes straight to DRAIN); RUN stays RUN on gaps (req_en=0); DRAIN counts 2-bit drain_cnt 0..2, then IDLE with grp_cnt cleared.
- During DRAIN req_en is ignored, no bank reads, overrun_err set.
- grp_cnt increments per accepted group (req_en=1 in IDLE/RUN), including groups with all slots idle.

## Timing
- Group sampled at edge of cycle n: bank_rd_en/bank_addr valid cycle n+1; bank_rdata cycle n+2; slot_valid/slot_rdata/l_out cycle n+3.
- done_out pulses in cycle n+3 for group n carrying req_done; coincides with DRAIN exit (drain_cnt=2) -> IDLE next cycle.
- Throughput one group per cycle, back-to-back, no stalls.
- Reset (asynchronous, any time): FSM IDLE, drain_cnt 0, bank_rd_en 0, bank_addr 0, slot_valid 0, slot_rdata 0, l_out 0, done_out 0, conflict_err 0, overrun_err 0, grp_cnt 0, pipeline owner tables cleared; in-flight groups discarded, no done_out produced.
- Sticky errors clear only by reset.

## Test plan
- Single group: req_bn slot s = s (s=0..15), ma = 15-s, SRAM model returns {bank,addr} -> cycle n+1 bank_rd_en=16'hFFFF, bank_addr[b]=15-b; cycle n+3 slot_valid=16'hFFFF, slot_rdata[s]={s,15-s}.
- Alternating pattern: even groups slots 0,1,4,5,8,9,12,13 live, odd groups others bn=16, 8 groups back-to-back, last with req_done -> slot_valid alternates 16'h3333/16'hCCCC from n+3, one done_out with last group, grp_cnt=8 before IDLE.
- Conflict: slots 3 and 7 both bn=5 -> only slot 3 valid, bank_addr[5]=slot 3 ma, conflict_err=1 and stays 1.
- Overrun: req_en held high one cycle after req_done group -> no bank_rd_en for it, overrun_err=1, done_out still exactly once.
- Reset mid-stream: rst low during cycle n+2 of 4-group burst -> all outputs 0 immediately, no slot_valid/done_out after release, grp_cnt=0.
- l alignment: req_l 0..5 on successive groups -> l_out 0..5 in matching cycles n+3.
